b_dispatcher_m: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/b_dispatcher_m_if.sv | 33 +++
 rtl/onehot_prio_enc.sv | 30 +++
 rtl/b_dispatcher_m.sv | 109 ++++++++++
 tb/tb_b_dispatcher_m.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite constants and BRESP encodings
// Purpose: BRESP encodings and default widths used across the interconnect.
// Ports: none (package).
package axi_lite_pkg;

  localparam int DEF_TRANS_WR_RESP_W = 2;
  localparam int DEF_NUM_MASTERS     = 16;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

endpackage

// File: rtl/b_dispatcher_m_if.sv
// rtl/b_dispatcher_m_if.sv - B-channel bundle between one slave and NUM_MASTERS masters
// Purpose: groups the write-response handshake and the one-hot master select.
// Ports (signals):
//   m_axi_bresp_o / m_axi_bvalid_o / m_axi_bready_i : per-master B channel
//   s_axi_bresp_i / s_axi_bvalid_i / s_axi_bready_o : slave B channel
//   Master_ID_Selected_i                            : one-hot destination select
// Modports: slave = the dispatcher, master = the surrounding fabric.
interface b_dispatcher_m_if
  import axi_lite_pkg::*;
#(
  parameter int TRANS_WR_RESP_W = DEF_TRANS_WR_RESP_W,
  parameter int NUM_MASTERS     = DEF_NUM_MASTERS
);

  logic [TRANS_WR_RESP_W*NUM_MASTERS-1:0] m_axi_bresp_o;
  logic [NUM_MASTERS-1:0]                 m_axi_bvalid_o;
  logic [NUM_MASTERS-1:0]                 m_axi_bready_i;
  logic [TRANS_WR_RESP_W-1:0]             s_axi_bresp_i;
  logic                                   s_axi_bvalid_i;
  logic                                   s_axi_bready_o;
  logic [NUM_MASTERS-1:0]                 Master_ID_Selected_i;

  modport slave (
    output m_axi_bresp_o, m_axi_bvalid_o, s_axi_bready_o,
    input  m_axi_bready_i, s_axi_bresp_i, s_axi_bvalid_i, Master_ID_Selected_i
  );

  modport master (
    input  m_axi_bresp_o, m_axi_bvalid_o, s_axi_bready_o,
    output m_axi_bready_i, s_axi_bresp_i, s_axi_bvalid_i, Master_ID_Selected_i
  );

endinterface

// File: rtl/onehot_prio_enc.sv
// rtl/onehot_prio_enc.sv - highest-set-bit encoder with hit and multi-hot flags
// Purpose: MSB-first priority encode of a select vector.
// Ports:
//   vec_i   : input vector (WIDTH bits)
//   idx_o   : index of the highest set bit (0 when vec_i is zero)
//   hit_o   : any bit set
//   multi_o : more than one bit set
module onehot_prio_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             hit_o,
  output logic             multi_o
);

  // Ascending scan: the last set bit visited (the highest) wins.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign hit_o = |vec_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(vec_i & (vec_i - WIDTH'(1)));

endmodule

// File: rtl/b_dispatcher_m.sv
// rtl/b_dispatcher_m.sv - routes one slave's B response to one of NUM_MASTERS masters
// Purpose: forwards bresp/bvalid to the master chosen by the highest set bit of
//   Master_ID_Selected_i and returns that master's bready to the slave.
//   Raises a sticky error flag whenever a multi-hot select is sampled.
// Ports:
//   clk             : system clock, rising edge
//   rst_n           : asynchronous active-low reset
//   bus             : b_dispatcher_m_if.slave (B channels + one-hot select)
//   err_multi_sel_o : sticky multi-hot select flag
// Option: define B_DISPATCHER_REG_SLICE_EN to insert a one-entry register slice.
module b_dispatcher_m
  import axi_lite_pkg::*;
#(
  parameter int TRANS_WR_RESP_W = DEF_TRANS_WR_RESP_W,
  parameter int NUM_MASTERS     = DEF_NUM_MASTERS
) (
  input  logic             clk,
  input  logic             rst_n,
  b_dispatcher_m_if.slave  bus,
  output logic             err_multi_sel_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDX_W-1:0] sel;
  logic             hit;
  logic             multi;

  logic [TRANS_WR_RESP_W*NUM_MASTERS-1:0] bresp_out;
  logic [NUM_MASTERS-1:0]                 bvalid_out;
  logic                                   bready_out;

  onehot_prio_enc #(
    .WIDTH (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i   (bus.Master_ID_Selected_i),
    .idx_o   (sel),
    .hit_o   (hit),
    .multi_o (multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_multi_sel_o <= 1'b0;
    end else if (multi) begin
      err_multi_sel_o <= 1'b1;
    end
  end

`ifdef B_DISPATCHER_REG_SLICE_EN

  logic                       full;
  logic [TRANS_WR_RESP_W-1:0] st_bresp;
  logic [NUM_MASTERS-1:0]     st_dest;
  logic                       drain;
  logic                       capture;

  assign drain      = full && |(bus.m_axi_bready_i & st_dest);
  assign bready_out = !full || drain;
  assign capture    = bus.s_axi_bvalid_i && bready_out && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      st_bresp <= '0;
      st_dest  <= '0;
    end else if (capture) begin
      // Covers the simultaneous drain+capture case: the new beat replaces the old.
      full     <= 1'b1;
      st_bresp <= bus.s_axi_bresp_i;
      st_dest  <= NUM_MASTERS'(1) << sel;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  always_comb begin
    bresp_out  = '0;
    bvalid_out = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (full && st_dest[i]) begin
        bvalid_out[i]                                  = 1'b1;
        bresp_out[i*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = st_bresp;
      end
    end
  end

`else

  // Zero-latency path; bresp follows the select even while bvalid is low.
  always_comb begin
    bresp_out  = '0;
    bvalid_out = '0;
    bready_out = 1'b0;
    if (hit) begin
      bvalid_out[sel]                                    = bus.s_axi_bvalid_i;
      bresp_out[sel*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = bus.s_axi_bresp_i;
      bready_out                                         = bus.m_axi_bready_i[sel];
    end
  end

`endif

  assign bus.m_axi_bresp_o  = bresp_out;
  assign bus.m_axi_bvalid_o = bvalid_out;
  assign bus.s_axi_bready_o = bready_out;

endmodule

// File: tb/tb_b_dispatcher_m.sv
// tb/tb_b_dispatcher_m.sv - directed self-checking bench for b_dispatcher_m
module tb_b_dispatcher_m;

  logic clk;
  logic rst_n;
  logic err_multi_sel;
  int   errors;
  int   checks;

  b_dispatcher_m_if #(.TRANS_WR_RESP_W(2), .NUM_MASTERS(16)) bus ();

  b_dispatcher_m #(.TRANS_WR_RESP_W(2), .NUM_MASTERS(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .err_multi_sel_o (err_multi_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [15:0] sel, input logic [1:0] br,
                       input logic bv, input logic [15:0] brdy);
    @(negedge clk);
    bus.Master_ID_Selected_i = sel;
    bus.s_axi_bresp_i        = br;
    bus.s_axi_bvalid_i       = bv;
    bus.m_axi_bready_i       = brdy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Master_ID_Selected_i = '0;
    bus.s_axi_bresp_i        = '0;
    bus.s_axi_bvalid_i       = 1'b0;
    bus.m_axi_bready_i       = '0;
    #12;
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0) begin errors++;
      $display("FAIL reset_bvalid got=%h exp=%h", bus.m_axi_bvalid_o, 16'h0); end
    checks++;
    if (bus.m_axi_bresp_o !== 32'h0) begin errors++;
      $display("FAIL reset_bresp got=%h exp=%h", bus.m_axi_bresp_o, 32'h0); end
    checks++;
    if (err_multi_sel !== 1'b0) begin errors++;
      $display("FAIL reset_err got=%b exp=0", err_multi_sel); end
`ifdef B_DISPATCHER_REG_SLICE_EN
    checks++;
    if (bus.s_axi_bready_o !== 1'b1) begin errors++;
      $display("FAIL reset_bready got=%b exp=1", bus.s_axi_bready_o); end
`else
    checks++;
    if (bus.s_axi_bready_o !== 1'b0) begin errors++;
      $display("FAIL reset_bready got=%b exp=0", bus.s_axi_bready_o); end
`endif
    rst_n = 1'b1;
  endtask

`ifdef B_DISPATCHER_REG_SLICE_EN
  task automatic test_reg_slice();
    drive(16'h0004, 2'b11, 1'b1, 16'h0000);
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0 || bus.s_axi_bready_o !== 1'b1) begin errors++;
      $display("FAIL slice_pre got=%h/%b exp=0000/1", bus.m_axi_bvalid_o, bus.s_axi_bready_o); end
    @(posedge clk); #1;
    bus.s_axi_bvalid_i = 1'b0;
    #1;
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0004 || bus.m_axi_bresp_o !== 32'h0000_0030) begin errors++;
      $display("FAIL slice_cap got=%h/%h exp=0004/00000030", bus.m_axi_bvalid_o, bus.m_axi_bresp_o); end
    checks++;
    if (bus.s_axi_bready_o !== 1'b0) begin errors++;
      $display("FAIL slice_stall got=%b exp=0", bus.s_axi_bready_o); end
    @(posedge clk); #1;
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0004) begin errors++;
      $display("FAIL slice_hold got=%h exp=0004", bus.m_axi_bvalid_o); end
    drive(16'h0004, 2'b11, 1'b0, 16'h0004);
    checks++;
    if (bus.s_axi_bready_o !== 1'b1) begin errors++;
      $display("FAIL slice_drain_rdy got=%b exp=1", bus.s_axi_bready_o); end
    @(posedge clk); #1;
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0) begin errors++;
      $display("FAIL slice_drained got=%h exp=0000", bus.m_axi_bvalid_o); end
    drive(16'h0100, 2'b10, 1'b1, 16'h0000);
    @(posedge clk); #1;
    bus.s_axi_bvalid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0 || bus.m_axi_bresp_o !== 32'h0) begin errors++;
      $display("FAIL slice_reset got=%h/%h exp=0000/00000000", bus.m_axi_bvalid_o, bus.m_axi_bresp_o); end
    rst_n = 1'b1;
  endtask
`else
  task automatic test_master0();
    drive(16'h0001, 2'b00, 1'b1, 16'h0001);
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0001 || bus.m_axi_bresp_o !== 32'h0) begin errors++;
      $display("FAIL m0_out got=%h/%h exp=0001/00000000", bus.m_axi_bvalid_o, bus.m_axi_bresp_o); end
    checks++;
    if (bus.s_axi_bready_o !== 1'b1) begin errors++;
      $display("FAIL m0_bready got=%b exp=1", bus.s_axi_bready_o); end
  endtask

  task automatic test_sweep();
    drive(16'h0020, 2'b10, 1'b1, 16'h0020);
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0020 || bus.m_axi_bresp_o !== 32'h0000_0800) begin errors++;
      $display("FAIL m5_slverr got=%h/%h exp=0020/00000800", bus.m_axi_bvalid_o, bus.m_axi_bresp_o); end
    checks++;
    if (bus.s_axi_bready_o !== 1'b1) begin errors++;
      $display("FAIL m5_bready got=%b exp=1", bus.s_axi_bready_o); end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] oh;
      oh = 16'h1 << i;
      drive(oh, 2'b00, 1'b1, ~oh);
      checks++;
      if (bus.m_axi_bvalid_o !== oh || bus.s_axi_bready_o !== 1'b0) begin errors++;
        $display("FAIL sweep_%0d_other_rdy got=%h/%b exp=%h/0", i, bus.m_axi_bvalid_o, bus.s_axi_bready_o, oh); end
      bus.m_axi_bready_i = oh;
      #1;
      checks++;
      if (bus.s_axi_bready_o !== 1'b1) begin errors++;
        $display("FAIL sweep_%0d_rdy got=%b exp=1", i, bus.s_axi_bready_o); end
    end
  endtask

  task automatic test_no_hit_stall();
    drive(16'h0000, 2'b11, 1'b0, 16'h0000);
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0 || bus.m_axi_bresp_o !== 32'h0 || bus.s_axi_bready_o !== 1'b0) begin errors++;
      $display("FAIL nohit got=%h/%h/%b exp=0000/00000000/0", bus.m_axi_bvalid_o, bus.m_axi_bresp_o, bus.s_axi_bready_o); end
    drive(16'h0008, 2'b01, 1'b1, 16'hFFF7);
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0008 || bus.m_axi_bresp_o !== 32'h0000_0040 || bus.s_axi_bready_o !== 1'b0) begin errors++;
      $display("FAIL m3_stall got=%h/%h/%b exp=0008/00000040/0", bus.m_axi_bvalid_o, bus.m_axi_bresp_o, bus.s_axi_bready_o); end
    bus.m_axi_bready_i = 16'h0008;
    #1;
    checks++;
    if (bus.s_axi_bready_o !== 1'b1) begin errors++;
      $display("FAIL m3_ready got=%b exp=1", bus.s_axi_bready_o); end
  endtask

  task automatic test_multi_hot();
    drive(16'h0003, 2'b10, 1'b1, 16'h0002);
    checks++;
    if (bus.m_axi_bvalid_o !== 16'h0002 || bus.m_axi_bresp_o !== 32'h0000_0008 || bus.s_axi_bready_o !== 1'b1) begin errors++;
      $display("FAIL multi_route got=%h/%h/%b exp=0002/00000008/1", bus.m_axi_bvalid_o, bus.m_axi_bresp_o, bus.s_axi_bready_o); end
    checks++;
    if (err_multi_sel !== 1'b0) begin errors++;
      $display("FAIL multi_err_pre got=%b exp=0", err_multi_sel); end
    @(posedge clk); #1;
    checks++;
    if (err_multi_sel !== 1'b1) begin errors++;
      $display("FAIL multi_err_set got=%b exp=1", err_multi_sel); end
    drive(16'h0010, 2'b00, 1'b0, 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (err_multi_sel !== 1'b1) begin errors++;
      $display("FAIL multi_err_sticky got=%b exp=1", err_multi_sel); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_multi_sel !== 1'b0) begin errors++;
      $display("FAIL multi_err_clear got=%b exp=0", err_multi_sel); end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int          m;
      logic [1:0]  br;
      logic        b;
      logic [31:0] exp_resp;
      logic [15:0] exp_vld;
      m  = int'($urandom_range(0, 15));
      br = 2'($urandom_range(0, 3));
      b  = 1'($urandom_range(0, 1));
      exp_resp = 32'(br) << (m * 2);
      exp_vld  = 16'(b) << m;
      drive(16'h1 << m, br, b, {16{b}});
      checks++;
      if (bus.m_axi_bresp_o !== exp_resp || bus.m_axi_bvalid_o !== exp_vld || bus.s_axi_bready_o !== b) begin errors++;
        $display("FAIL rand_%0d got=%h/%h/%b exp=%h/%h/%b", k, bus.m_axi_bresp_o, bus.m_axi_bvalid_o,
                 bus.s_axi_bready_o, exp_resp, exp_vld, b); end
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
`ifdef B_DISPATCHER_REG_SLICE_EN
    test_reg_slice();
`else
    test_master0();
    test_sweep();
    test_no_hit_stall();
    test_multi_hot();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
